// File: rtl/alu_unit.sv
// alu_unit: 32-bit registered integer ALU with carry/zero/sign flags.
// Result and flags update one cycle after a valid request and hold otherwise.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ALUsel,
    input  logic [4:0]       ALUop,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign
);
    localparam logic [WIDTH:0] ONE = 1;
    logic [WIDTH-1:0] op2;
    logic [4:0]       sh;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   s;
    assign op2 = ALUsel ? {{(WIDTH-16){b[15]}}, b[15:0]} : b;
    assign sh  = op2[4:0];
    // t packs {carry, result}; right shifts append a guard bit below a so the
    // last bit shifted out lands in s[0].
    always_comb begin
        t = '0;
        s = '0;
        case (ALUop)
            5'b00000: t = {1'b0, a};
            5'b00001: t = {1'b0, a} + {1'b0, op2};
            5'b00101: t = {1'b0, ~op2} + ONE;
            5'b10101: t = {1'b0, a} + {1'b0, ~op2} + ONE;
            5'b00010: t = {1'b0, a & op2};
            5'b00011: t = {1'b0, a ^ op2};
            5'b01010: t = {1'b0, a} << sh;
            5'b01000: begin
                s = {a, 1'b0} >> sh;
                t = {s[0], s[WIDTH:1]};
            end
            5'b01001: begin
                s = $signed({a, 1'b0}) >>> sh;
                t = {s[0], s[WIDTH:1]};
            end
            default: t = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result <= t[WIDTH-1:0];
                carry  <= t[WIDTH];
                zero   <= (t[WIDTH-1:0] == '0);
                sign   <= t[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and random checks of alu_unit against an arithmetic model.
module tb_alu_unit;
    localparam logic [4:0] PASS = 5'b00000, ADD = 5'b00001, COMP = 5'b00101, SUB = 5'b10101,
                           AND_ = 5'b00010, XOR_ = 5'b00011, SLL = 5'b01010, SRL = 5'b01000,
                           SRA = 5'b01001, ILL = 5'b11111;
    logic        clk, rst, valid_in, ALUsel, valid_out, carry, zero, sign;
    logic [31:0] a, b, result;
    logic [4:0]  ALUop;
    logic [31:0] er;
    logic        ec, ez, es, ev;
    int          n = 0, fails = 0;
    alu_unit dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b), .ALUsel(ALUsel),
        .ALUop(ALUop), .valid_out(valid_out), .result(result), .carry(carry),
        .zero(zero), .sign(sign)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    function automatic void model(input logic [4:0] op, input logic [31:0] x, y,
                                  input logic sel, output logic [31:0] r, output logic c);
        logic [31:0]     o;
        longint unsigned s;
        int              sh;
        o  = sel ? 32'($signed(y[15:0])) : y;
        sh = int'(o[4:0]);
        r  = 0;
        c  = 0;
        case (op)
            PASS: r = x;
            ADD:  begin s = 64'(x) + 64'(o); r = s[31:0]; c = s[32]; end
            COMP: begin r = -o; c = (o == 0); end
            SUB:  begin r = x - o; c = (x >= o); end
            AND_: r = x & o;
            XOR_: r = x ^ o;
            SLL:  begin r = x << sh; c = (sh == 0) ? 1'b0 : x[32-sh]; end
            SRL:  begin r = x >> sh; c = (sh == 0) ? 1'b0 : x[sh-1]; end
            SRA:  begin r = $signed(x) >>> sh; c = (sh == 0) ? 1'b0 : x[sh-1]; end
            default: begin r = 0; c = 0; end
        endcase
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic step(input logic [4:0] op, input logic [31:0] ia, ib, input logic sel,
                        input logic v, input logic r);
        rst = r; valid_in = v; ALUop = op; a = ia; b = ib; ALUsel = sel;
        @(posedge clk);
        #1;
        if (r) begin
            er = 0; ec = 0; ez = 0; es = 0; ev = 0;
        end else begin
            ev = v;
            if (v) begin
                model(op, ia, ib, sel, er, ec);
                ez = (er == 0);
                es = er[31];
            end
        end
        chk("result", result, er);
        chk("carry", 32'(carry), 32'(ec));
        chk("zero", 32'(zero), 32'(ez));
        chk("sign", 32'(sign), 32'(es));
        chk("valid_out", 32'(valid_out), 32'(ev));
    endtask
    // Runs a step and also pins the outcome to a hand-computed result and carry.
    task automatic step_k(input logic [4:0] op, input logic [31:0] ia, ib, input logic sel,
                          input logic [31:0] kr, input logic kc);
        step(op, ia, ib, sel, 1'b1, 1'b0);
        chk("known_result", result, kr);
        chk("known_carry", 32'(carry), 32'(kc));
    endtask
    initial begin
        logic [4:0] ops [10];
        ops = '{PASS, ADD, COMP, SUB, AND_, XOR_, SLL, SRL, SRA, ILL};
        step(ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1);
        step(ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1);
        step_k(ADD,  32'hFFFC1FFF, 32'd7, 1'b0, 32'hFFFC2006, 1'b0);
        step_k(COMP, 32'hFFFC1FFF, 32'd7, 1'b0, 32'hFFFFFFF9, 1'b0);
        step_k(SUB,  32'hFFFC1FFF, 32'd7, 1'b0, 32'hFFFC1FF8, 1'b1);
        step_k(AND_, 32'hFFFC1FFF, 32'd7, 1'b0, 32'h00000007, 1'b0);
        step_k(XOR_, 32'hFFFC1FFF, 32'd7, 1'b0, 32'hFFFC1FF8, 1'b0);
        step_k(PASS, 32'hFFFC1FFF, 32'd7, 1'b0, 32'hFFFC1FFF, 1'b0);
        step_k(SLL,  32'hFFFC1FFF, 32'd7, 1'b0, 32'hFE0FFF80, 1'b1);
        step_k(SRL,  32'hFFFC1FFF, 32'd7, 1'b0, 32'h01FFF83F, 1'b1);
        step_k(SRA,  32'hFFFC1FFF, 32'd7, 1'b0, 32'hFFFFF83F, 1'b1);
        step_k(SLL,  32'hFFFC1FFF, 32'd32, 1'b0, 32'hFFFC1FFF, 1'b0);
        step_k(SRA,  32'hFFFC1FFF, 32'd32, 1'b0, 32'hFFFC1FFF, 1'b0);
        step_k(XOR_, 32'h12345678, 32'h12345678, 1'b0, 32'h0, 1'b0);
        chk("xor_zero", 32'(zero), 32'd1);
        step_k(ADD,  32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1);
        chk("add_zero", 32'(zero), 32'd1);
        step_k(COMP, 32'h1234, 32'h0, 1'b0, 32'h0, 1'b1);
        step_k(SUB,  32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 1'b0);
        step_k(ADD,  32'd5, 32'hABCDFFF9, 1'b1, 32'hFFFFFFFE, 1'b0);
        chk("imm_sign", 32'(sign), 32'd1);
        step_k(ADD,  32'd5, 32'hABCDFFF9, 1'b0, 32'hABCDFFFE, 1'b0);
        step_k(SUB,  32'd10, 32'h0000FFFF, 1'b1, 32'd11, 1'b0);
        for (int i = 0; i < 3; i++)
            step(ops[i], $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
        chk("hold_result", result, 32'd11);
        step_k(ILL, 32'hDEADBEEF, 32'h1, 1'b0, 32'h0, 1'b0);
        chk("ill_zero", 32'(zero), 32'd1);
        step(ADD, 32'h7, 32'h9, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++)
            step(ops[$urandom_range(9)], $urandom, ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom,
                 1'($urandom), $urandom_range(4) != 0, $urandom_range(39) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
